// File: rtl/tdm_demux4_pkg.sv
// Shared TDM definitions: slot count and slot encoding used by both the
// mux-side transmitter and the demux-side receiver.
package tdm_pkg;

  localparam int unsigned NUM_SLOTS = 4;

  typedef enum logic [1:0] {
    SLOT0,
    SLOT1,
    SLOT2,
    SLOT3
  } slot_t;

endpackage

// File: rtl/tdm_demux4_if.sv
// Bus bundle for the 4-slot TDM demux: serial input beat handshake,
// parallel frame output handshake and debug/status signals.
interface tdm_demux4_if #(
  parameter int unsigned WIDTH = 8
) ();

  logic [WIDTH-1:0] din;
  logic             din_valid;
  logic             din_sof;
  logic             din_ready;
  logic [WIDTH-1:0] d0;
  logic [WIDTH-1:0] d1;
  logic [WIDTH-1:0] d2;
  logic [WIDTH-1:0] d3;
  logic             out_valid;
  logic             out_ready;
  logic [1:0]       slot;
  logic             frame_err;

  // Producer of serial beats and consumer of parallel frames
  modport master (
    output din, din_valid, din_sof, out_ready,
    input  din_ready, d0, d1, d2, d3, out_valid, slot, frame_err
  );

  // The demux itself
  modport slave (
    input  din, din_valid, din_sof, out_ready,
    output din_ready, d0, d1, d2, d3, out_valid, slot, frame_err
  );

endinterface

// File: rtl/tdm_demux4.sv
// 4-slot TDM demultiplexer: steers accepted serial beats into a staging
// bank by slot counter and presents each complete frame as four parallel
// words behind a valid/ready handshake.
module tdm_demux4
  import tdm_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input logic          clk,
  input logic          rst_n,
  tdm_demux4_if.slave  bus
);

  slot_t slot_q, slot_d;

  // Slots 0..NUM_SLOTS-2 are staged; the last word goes straight from din
  // into the output register on the completing edge.
  logic [NUM_SLOTS-2:0][WIDTH-1:0] stage_q, stage_d;
  logic [NUM_SLOTS-1:0][WIDTH-1:0] dout_q, dout_d;
  logic                            out_valid_q, out_valid_d;
  logic                            frame_err_q, frame_err_d;

  logic din_ready;
  logic accept;
  logic complete;

  // State and datapath registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      slot_q      <= SLOT0;
      stage_q     <= '0;
      dout_q      <= '0;
      out_valid_q <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      slot_q      <= slot_d;
      stage_q     <= stage_d;
      dout_q      <= dout_d;
      out_valid_q <= out_valid_d;
      frame_err_q <= frame_err_d;
    end
  end

  // Next slot: sof restarts at slot 1, otherwise advance with wrap
  always_comb begin
    slot_d = slot_q;
    if (accept) begin
      if (bus.din_sof) begin
        slot_d = SLOT1;
      end else begin
        case (slot_q)
          SLOT0:   slot_d = SLOT1;
          SLOT1:   slot_d = SLOT2;
          SLOT2:   slot_d = SLOT3;
          SLOT3:   slot_d = SLOT0;
          default: slot_d = SLOT0;
        endcase
      end
    end
  end

  // Handshake decode: only the completing beat stalls on a pending frame
  always_comb begin
    din_ready = rst_n && !((slot_q == SLOT3) && out_valid_q && !bus.out_ready);
    accept    = bus.din_valid && din_ready;
    complete  = accept && !bus.din_sof && (slot_q == SLOT3);
  end

  // Staging writes, frame hand-off and error pulse
  always_comb begin
    stage_d     = stage_q;
    dout_d      = dout_q;
    out_valid_d = out_valid_q;
    frame_err_d = 1'b0;

    if (accept) begin
      if (bus.din_sof) begin
        stage_d[0]  = bus.din;
        frame_err_d = (slot_q != SLOT0);
      end else begin
        case (slot_q)
          SLOT0:   stage_d[0] = bus.din;
          SLOT1:   stage_d[1] = bus.din;
          SLOT2:   stage_d[2] = bus.din;
          default: ;
        endcase
      end
    end

    // Consume first, then let a same-edge completion re-assert valid
    if (bus.out_ready) begin
      out_valid_d = 1'b0;
    end
    if (complete) begin
      dout_d      = {bus.din, stage_q[2], stage_q[1], stage_q[0]};
      out_valid_d = 1'b1;
    end
  end

  // Drive interface outputs
  always_comb begin
    bus.din_ready = din_ready;
    bus.d0        = dout_q[0];
    bus.d1        = dout_q[1];
    bus.d2        = dout_q[2];
    bus.d3        = dout_q[3];
    bus.out_valid = out_valid_q;
    bus.slot      = slot_q;
    bus.frame_err = frame_err_q;
  end

endmodule

// File: tb/tb_tdm_demux4.sv
// Directed bench for tdm_demux4: a vector table of per-cycle inputs and
// expected outputs, followed by hand-written handshake sequences.
module tb_tdm_demux4;

  logic clk;
  logic rst_n;

  tdm_demux4_if #(.WIDTH(8)) bus ();

  tdm_demux4 #(.WIDTH(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst_n;
    logic        vld;
    logic        sof;
    logic [7:0]  din;
    logic        ordy;
    logic        e_rdy;
    logic [1:0]  e_slot;
    logic        e_ov;
    logic        e_err;
    logic [31:0] e_d;   // {d0,d1,d2,d3}
  } vec_t;

  vec_t vecs[$];
  int n_checks;
  int n_fail;

  task automatic add(input logic r, input logic v, input logic s,
                     input logic [7:0] d, input logic o, input logic er,
                     input logic [1:0] es, input logic eov, input logic ee,
                     input logic [31:0] ed);
    vec_t t;
    t.rst_n = r; t.vld = v; t.sof = s; t.din = d; t.ordy = o;
    t.e_rdy = er; t.e_slot = es; t.e_ov = eov; t.e_err = ee; t.e_d = ed;
    vecs.push_back(t);
  endtask

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] dword();
    return {bus.d0, bus.d1, bus.d2, bus.d3};
  endfunction

  task automatic send_beat(input logic [7:0] d, input logic s);
    int unsigned n;
    n = 0;
    @(negedge clk);
    bus.din = d; bus.din_sof = s; bus.din_valid = 1'b1;
    #1;
    while (!bus.din_ready && n < 8) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (!bus.din_ready) check("beat_accept_timeout", 32'(bus.din_ready), 32'd1);
    @(posedge clk);
    #1;
    bus.din_valid = 1'b0;
    bus.din_sof   = 1'b0;
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst_n = 1'b0;
    bus.din = '0; bus.din_valid = 1'b0; bus.din_sof = 1'b0; bus.out_ready = 1'b0;

    //   rst v  sof din    ordy rdy slot ov err  d0d1d2d3
    // reset; din_ready forced low even with a valid beat offered
    add(0, 0, 0, 8'h00, 0,  0, 0, 0, 0, 32'h00000000);
    add(0, 1, 1, 8'h99, 1,  0, 0, 0, 0, 32'h00000000);
    // frame 11..44, consumer ready
    add(1, 1, 1, 8'h11, 1,  1, 1, 0, 0, 32'h00000000);
    add(1, 1, 0, 8'h22, 1,  1, 2, 0, 0, 32'h00000000);
    add(1, 1, 0, 8'h33, 1,  1, 3, 0, 0, 32'h00000000);
    add(1, 1, 0, 8'h44, 1,  1, 0, 1, 0, 32'h11223344);
    // backpressure: A0..A2 accepted, A3 stalls (also with sof), then
    // completes on the consuming edge with no bubble
    add(1, 1, 1, 8'hA0, 0,  1, 1, 1, 0, 32'h11223344);
    add(1, 1, 0, 8'hA1, 0,  1, 2, 1, 0, 32'h11223344);
    add(1, 1, 0, 8'hA2, 0,  1, 3, 1, 0, 32'h11223344);
    add(1, 1, 0, 8'hA3, 0,  0, 3, 1, 0, 32'h11223344);
    add(1, 1, 1, 8'hA3, 0,  0, 3, 1, 0, 32'h11223344);
    add(1, 1, 0, 8'hA3, 1,  1, 0, 1, 0, 32'hA0A1A2A3);
    add(1, 0, 0, 8'h00, 1,  1, 0, 0, 0, 32'hA0A1A2A3);
    // partial frame dropped by sof in slot 2
    add(1, 1, 1, 8'h01, 1,  1, 1, 0, 0, 32'hA0A1A2A3);
    add(1, 1, 0, 8'h02, 1,  1, 2, 0, 0, 32'hA0A1A2A3);
    add(1, 1, 1, 8'h55, 1,  1, 1, 0, 1, 32'hA0A1A2A3);
    add(1, 1, 0, 8'h66, 1,  1, 2, 0, 0, 32'hA0A1A2A3);
    add(1, 1, 0, 8'h77, 1,  1, 3, 0, 0, 32'hA0A1A2A3);
    add(1, 1, 0, 8'h88, 1,  1, 0, 1, 0, 32'h55667788);
    // gapped valid; idle sof is ignored
    add(1, 1, 1, 8'hB0, 1,  1, 1, 0, 0, 32'h55667788);
    add(1, 0, 0, 8'hFF, 1,  1, 1, 0, 0, 32'h55667788);
    add(1, 1, 0, 8'hB1, 1,  1, 2, 0, 0, 32'h55667788);
    add(1, 0, 1, 8'hEE, 1,  1, 2, 0, 0, 32'h55667788);
    add(1, 1, 0, 8'hB2, 1,  1, 3, 0, 0, 32'h55667788);
    add(1, 0, 0, 8'hDD, 1,  1, 3, 0, 0, 32'h55667788);
    add(1, 1, 0, 8'hB3, 1,  1, 0, 1, 0, 32'hB0B1B2B3);
    // reset with slot=2 and a pending frame, then a frame without sof
    add(1, 1, 1, 8'hC0, 0,  1, 1, 1, 0, 32'hB0B1B2B3);
    add(1, 1, 0, 8'hC1, 0,  1, 2, 1, 0, 32'hB0B1B2B3);
    add(0, 1, 0, 8'hC2, 0,  0, 0, 0, 0, 32'h00000000);
    add(1, 1, 0, 8'h0F, 1,  1, 1, 0, 0, 32'h00000000);
    add(1, 1, 0, 8'h0E, 1,  1, 2, 0, 0, 32'h00000000);
    add(1, 1, 0, 8'h0D, 1,  1, 3, 0, 0, 32'h00000000);
    add(1, 1, 0, 8'h0C, 1,  1, 0, 1, 0, 32'h0F0E0D0C);
    add(1, 0, 0, 8'h00, 1,  1, 0, 0, 0, 32'h0F0E0D0C);
    // sof in slot 3 restarts instead of completing
    add(1, 1, 1, 8'h21, 1,  1, 1, 0, 0, 32'h0F0E0D0C);
    add(1, 1, 0, 8'h22, 1,  1, 2, 0, 0, 32'h0F0E0D0C);
    add(1, 1, 0, 8'h23, 1,  1, 3, 0, 0, 32'h0F0E0D0C);
    add(1, 1, 1, 8'h31, 1,  1, 1, 0, 1, 32'h0F0E0D0C);
    add(1, 1, 0, 8'h32, 1,  1, 2, 0, 0, 32'h0F0E0D0C);
    add(1, 1, 0, 8'h33, 1,  1, 3, 0, 0, 32'h0F0E0D0C);
    add(1, 1, 0, 8'h34, 0,  1, 0, 1, 0, 32'h31323334);

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      rst_n         = vecs[i].rst_n;
      bus.din_valid = vecs[i].vld;
      bus.din_sof   = vecs[i].sof;
      bus.din       = vecs[i].din;
      bus.out_ready = vecs[i].ordy;
      #1;
      check($sformatf("v%0d_din_ready", i), 32'(bus.din_ready), 32'(vecs[i].e_rdy));
      @(posedge clk);
      #1;
      check($sformatf("v%0d_slot", i),      32'(bus.slot),      32'(vecs[i].e_slot));
      check($sformatf("v%0d_out_valid", i), 32'(bus.out_valid), 32'(vecs[i].e_ov));
      check($sformatf("v%0d_frame_err", i), 32'(bus.frame_err), 32'(vecs[i].e_err));
      check($sformatf("v%0d_data", i),      dword(),            vecs[i].e_d);
    end

    // Pending frame holds stable while the consumer is not ready
    bus.din_valid = 1'b0;
    bus.din_sof   = 1'b0;
    bus.out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      check($sformatf("hold%0d_valid", i), 32'(bus.out_valid), 32'd1);
      check($sformatf("hold%0d_data", i),  dword(),            32'h31323334);
    end
    @(negedge clk);
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    check("consume_valid", 32'(bus.out_valid), 32'd0);

    // Beat-by-beat frame through the bounded handshake task
    send_beat(8'h61, 1'b1);
    send_beat(8'h62, 1'b0);
    send_beat(8'h63, 1'b0);
    send_beat(8'h64, 1'b0);
    begin
      int unsigned waited;
      waited = 0;
      while (!bus.out_valid && waited < 8) begin
        @(posedge clk);
        #1;
        waited++;
      end
      check("seq_out_valid", 32'(bus.out_valid), 32'd1);
      check("seq_data",      dword(),            32'h61626364);
      check("seq_slot",      32'(bus.slot),      32'd0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
